// File: rtl/isa_pkg.sv
// ===========================================================================
// Module   : isa_pkg
// Purpose  : ISA constants, opcode encoding and instruction decode helpers.
// Revision : 1.0  initial release
// ===========================================================================
`default_nettype none

package isa_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_W  = $clog2(NREGS);

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_R1   = 4'h1,
    OP_R2   = 4'h2,
    OP_R3   = 4'h3,
    OP_R4   = 4'h4,
    OP_R5   = 4'h5,
    OP_R6   = 4'h6,
    OP_R7   = 4'h7,
    OP_ADDI = 4'h8,
    OP_ST   = 4'h9
  } opcode_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             wr;
    logic             illegal;
  } dec_t;

  function automatic dec_t decode(input logic [DATA_W-1:0] instr);
    dec_t d;
    d.op       = instr[OP_MSB:OP_LSB];
    d.rd       = instr[RD_MSB:RD_LSB];
    d.rs1      = instr[RS1_MSB:RS1_LSB];
    d.rs2      = instr[RS2_MSB:RS2_LSB];
    d.uses_rs1 = 1'b0;
    d.uses_rs2 = 1'b0;
    d.wr       = 1'b0;
    d.illegal  = 1'b0;
    case (d.op)
      OP_NOP: ;
      OP_R1, OP_R2, OP_R3, OP_R4, OP_R5, OP_R6, OP_R7: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        d.wr       = 1'b1;
      end
      OP_ADDI: begin
        d.uses_rs1 = 1'b1;
        d.wr       = 1'b1;
      end
      OP_ST: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [DATA_W-1:0] instr);
    return {{(DATA_W-IMM_MSB-1){instr[IMM_MSB]}}, instr[IMM_MSB:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_issue_if.sv
// ===========================================================================
// Module   : decode_issue_if
// Purpose  : Fetch, register-file, writeback and ID/EX bundle of decode_issue.
// Revision : 1.0  initial release
// ===========================================================================
`default_nettype none

interface decode_issue_if;
  import isa_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic              in_ready;
  logic [REG_W-1:0]  rf_rs1;
  logic [REG_W-1:0]  rf_rs2;
  logic [DATA_W-1:0] rf_data_rs1;
  logic [DATA_W-1:0] rf_data_rs2;
  logic [REG_W-1:0]  rf_rd;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_we;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [REG_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_imm;
  logic              out_wr;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, rf_data_rs1, rf_data_rs2,
           wb_we, wb_rd, wb_data, out_ready,
    output in_ready, rf_rs1, rf_rs2, rf_rd, rf_data_in, rf_we,
           out_valid, out_op, out_rd, out_a, out_b, out_imm, out_wr, out_illegal
  );

  modport master (
    output in_valid, in_instr, rf_data_rs1, rf_data_rs2,
           wb_we, wb_rd, wb_data, out_ready,
    input  in_ready, rf_rs1, rf_rs2, rf_rd, rf_data_in, rf_we,
           out_valid, out_op, out_rd, out_a, out_b, out_imm, out_wr, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/decode_issue_scoreboard.sv
// ===========================================================================
// Module   : scoreboard
// Purpose  : Pending-write mask with set/clear ports and two busy lookups.
// Revision : 1.0  initial release
// ===========================================================================
`default_nettype none

module scoreboard
  import isa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] idx1_i,
  input  logic [REG_W-1:0] idx2_i,
  output logic             busy1_o,
  output logic             busy2_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_idx_i] = 1'b0;
    if (set_i) pending_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign busy1_o = pending_q[idx1_i];
  assign busy2_o = pending_q[idx2_i];

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// ===========================================================================
// Module   : decode_issue
// Purpose  : Decode/issue stage with RAW scoreboard, forwarding and ID/EX register.
// Revision : 1.0  initial release
// ===========================================================================
`default_nettype none

module decode_issue
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  decode_issue_if.slave bus
);

  dec_t              dec;
  logic              busy1, busy2, hit1, hit2, hazard, ready, accept;
  logic [DATA_W-1:0] opa, opb;

  logic              out_valid_q, out_valid_d;
  logic [3:0]        op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic              wr_q, wr_d, ill_q, ill_d;

  assign dec = decode(bus.in_instr);

  assign bus.rf_rs1     = dec.rs1;
  assign bus.rf_rs2     = dec.rs2;
  assign bus.rf_rd      = bus.wb_rd;
  assign bus.rf_data_in = bus.wb_data;
  assign bus.rf_we      = bus.wb_we;

  assign hit1 = bus.wb_we && (bus.wb_rd == dec.rs1);
  assign hit2 = bus.wb_we && (bus.wb_rd == dec.rs2);

  // A pending source is released by the writeback that lands this cycle.
  assign hazard = (dec.uses_rs1 && busy1 && !hit1) ||
                  (dec.uses_rs2 && busy2 && !hit2);
  assign ready  = !hazard && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign bus.in_ready = ready;

  assign opa = !dec.uses_rs1 ? '0 : (hit1 ? bus.wb_data : bus.rf_data_rs1);
  assign opb = !dec.uses_rs2 ? '0 : (hit2 ? bus.wb_data : bus.rf_data_rs2);

  scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (accept && dec.wr),
    .set_idx_i (dec.rd),
    .clr_i     (bus.wb_we),
    .clr_idx_i (bus.wb_rd),
    .idx1_i    (dec.rs1),
    .idx2_i    (dec.rs2),
    .busy1_o   (busy1),
    .busy2_o   (busy2)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    wr_d        = wr_q;
    ill_d       = ill_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op_d        = dec.op;
      rd_d        = dec.rd;
      a_d         = opa;
      b_d         = opb;
      imm_d       = sext_imm(bus.in_instr);
      wr_d        = dec.wr;
      ill_d       = dec.illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      wr_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      wr_q        <= wr_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = op_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_a       = a_q;
  assign bus.out_b       = b_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_wr      = wr_q;
  assign bus.out_illegal = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// ===========================================================================
// Module   : tb_decode_issue
// Purpose  : Directed vector bench for decode_issue with a behavioural register file.
// Revision : 1.0  initial release
// ===========================================================================
`default_nettype none

module tb_decode_issue;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decode_issue_if bus_i ();

  decode_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rf [8];

  assign bus_i.rf_data_rs1 = rf[bus_i.rf_rs1];
  assign bus_i.rf_data_rs2 = rf[bus_i.rf_rs2];

  initial begin
    rf[0] = 16'h0F0F; rf[1] = 16'h1010; rf[2] = 16'h1111; rf[3] = 16'h2222;
    rf[4] = 16'h4444; rf[5] = 16'h5555; rf[6] = 16'h6666; rf[7] = 16'h7777;
    forever begin
      @(posedge clk);
      if (bus_i.rf_we) rf[bus_i.rf_rd] <= bus_i.rf_data_in;
    end
  end

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pend();
    return {24'h0, dut.u_sb.pending_q};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_i.in_valid  = 1'b0;
    bus_i.in_instr  = 16'h0000;
    bus_i.wb_we     = 1'b0;
    bus_i.wb_rd     = 3'd0;
    bus_i.wb_data   = 16'h0000;
    bus_i.out_ready = 1'b1;

    vecs[0] = '{16'h1298, 4'h1, 3'd1, 16'h1111, 16'h2222, 16'h0018, 1'b1, 1'b0};
    vecs[1] = '{16'h8F7F, 4'h8, 3'd7, 16'h5555, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h9585, 4'h9, 3'd2, 16'h6666, 16'h0F0F, 16'h0005, 1'b0, 1'b0};
    vecs[3] = '{16'hC648, 4'hC, 3'd3, 16'h0000, 16'h0000, 16'h0008, 1'b0, 1'b1};
    vecs[4] = '{16'h0E3F, 4'h0, 3'd7, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{16'h71E0, 4'h7, 3'd0, 16'h7777, 16'h4444, 16'hFFE0, 1'b1, 1'b0};
    vecs[6] = '{16'h881F, 4'h8, 3'd4, 16'h0F0F, 16'h0000, 16'h001F, 1'b1, 1'b0};

    #12;
    chk("reset out_valid", {31'h0, bus_i.out_valid}, 32'h0);
    chk("reset out_a",     {16'h0, bus_i.out_a}, 32'h0);
    chk("reset pending",   pend(), 32'h0);
    chk("reset in_ready",  {31'h0, bus_i.in_ready}, 32'h1);
    rst_n = 1'b1;
    tick();

    // Isolated single-instruction decode checks, fresh reset for each.
    for (int i = 0; i < 7; i++) begin
      pulse_reset();
      bus_i.in_valid = 1'b1;
      bus_i.in_instr = vecs[i].instr;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'h0, bus_i.in_ready}, 32'h1);
      chk($sformatf("v%0d rf_rs1", i), {29'h0, bus_i.rf_rs1}, {29'h0, vecs[i].instr[8:6]});
      tick();
      bus_i.in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), {31'h0, bus_i.out_valid}, 32'h1);
      chk($sformatf("v%0d out_op", i),    {28'h0, bus_i.out_op}, {28'h0, vecs[i].op});
      chk($sformatf("v%0d out_rd", i),    {29'h0, bus_i.out_rd}, {29'h0, vecs[i].rd});
      chk($sformatf("v%0d out_a", i),     {16'h0, bus_i.out_a}, {16'h0, vecs[i].a});
      chk($sformatf("v%0d out_b", i),     {16'h0, bus_i.out_b}, {16'h0, vecs[i].b});
      chk($sformatf("v%0d out_imm", i),   {16'h0, bus_i.out_imm}, {16'h0, vecs[i].imm});
      chk($sformatf("v%0d out_wr", i),    {31'h0, bus_i.out_wr}, {31'h0, vecs[i].wr});
      chk($sformatf("v%0d out_illegal", i), {31'h0, bus_i.out_illegal}, {31'h0, vecs[i].ill});
      chk($sformatf("v%0d pending", i), pend(),
          vecs[i].wr ? (32'h1 << vecs[i].rd) : 32'h0);
    end

    // RAW hazard: r4 producer followed by an r4 consumer.
    pulse_reset();
    bus_i.in_valid = 1'b1;
    bus_i.in_instr = 16'h1898;
    tick();
    bus_i.in_instr = 16'h2B08;
    #1;
    chk("raw stall in_ready", {31'h0, bus_i.in_ready}, 32'h0);
    tick();
    chk("raw stall in_ready 2", {31'h0, bus_i.in_ready}, 32'h0);
    chk("raw stall out_valid drop", {31'h0, bus_i.out_valid}, 32'h0);
    bus_i.wb_we   = 1'b1;
    bus_i.wb_rd   = 3'd4;
    bus_i.wb_data = 16'hAAAA;
    #1;
    chk("raw wb in_ready", {31'h0, bus_i.in_ready}, 32'h1);
    chk("rf_we pass", {31'h0, bus_i.rf_we}, 32'h1);
    chk("rf_rd pass", {29'h0, bus_i.rf_rd}, 32'h4);
    chk("rf_data_in pass", {16'h0, bus_i.rf_data_in}, 32'hAAAA);
    tick();
    bus_i.wb_we = 1'b0;
    chk("raw fwd out_a", {16'h0, bus_i.out_a}, 32'hAAAA);
    chk("raw fwd out_b", {16'h0, bus_i.out_b}, 32'h1010);
    chk("raw fwd out_rd", {29'h0, bus_i.out_rd}, 32'h5);
    chk("raw pending", pend(), 32'h20);

    // Backpressure holds the ID/EX register and blocks the next instruction.
    bus_i.out_ready = 1'b0;
    bus_i.in_instr  = 16'h3C98;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d in_ready", c), {31'h0, bus_i.in_ready}, 32'h0);
      chk($sformatf("bp%0d out_valid", c), {31'h0, bus_i.out_valid}, 32'h1);
      chk($sformatf("bp%0d out_a", c), {16'h0, bus_i.out_a}, 32'hAAAA);
      chk($sformatf("bp%0d out_rd", c), {29'h0, bus_i.out_rd}, 32'h5);
      tick();
    end
    bus_i.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'h0, bus_i.in_ready}, 32'h1);
    tick();
    chk("bp load out_op", {28'h0, bus_i.out_op}, 32'h3);
    chk("bp load out_a", {16'h0, bus_i.out_a}, 32'h1111);
    chk("bp load out_b", {16'h0, bus_i.out_b}, 32'h2222);
    chk("bp load out_rd", {29'h0, bus_i.out_rd}, 32'h6);
    chk("bp pending", pend(), 32'h60);

    // Issue to r5 while r5's writeback lands: the new set must survive.
    bus_i.in_instr = 16'h4A98;
    bus_i.wb_we    = 1'b1;
    bus_i.wb_rd    = 3'd5;
    bus_i.wb_data  = 16'h5A5A;
    #1;
    chk("setclr in_ready", {31'h0, bus_i.in_ready}, 32'h1);
    tick();
    bus_i.wb_we = 1'b0;
    chk("setclr pending", pend(), 32'h60);
    chk("setclr out_op", {28'h0, bus_i.out_op}, 32'h4);

    // Reset while stalled on r6.
    bus_i.in_instr = 16'h11B0;
    #1;
    chk("rst stall in_ready", {31'h0, bus_i.in_ready}, 32'h0);
    tick();
    chk("rst stall in_ready 2", {31'h0, bus_i.in_ready}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", {31'h0, bus_i.out_valid}, 32'h0);
    chk("rst pending", pend(), 32'h0);
    chk("rst out_op", {28'h0, bus_i.out_op}, 32'h0);
    bus_i.in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    bus_i.in_valid = 1'b1;
    bus_i.in_instr = 16'h5560;
    #1;
    chk("post rst pre out_valid", {31'h0, bus_i.out_valid}, 32'h0);
    chk("post rst in_ready", {31'h0, bus_i.in_ready}, 32'h1);
    tick();
    bus_i.in_valid = 1'b0;
    chk("post rst out_valid", {31'h0, bus_i.out_valid}, 32'h1);
    chk("post rst out_a", {16'h0, bus_i.out_a}, 32'h5A5A);
    chk("post rst out_b", {16'h0, bus_i.out_b}, 32'hAAAA);
    chk("post rst pending", pend(), 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
